// File: rtl/rv32_issue_scoreboard_if.sv
// rtl/rv32_issue_scoreboard_if.sv - decode/issue/writeback handshake bundle for rv32_issue_scoreboard
interface rv32_issue_scoreboard_if #(
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          dec_valid;
  logic          dec_ready;
  logic [4:0]    dec_rs1;
  logic [4:0]    dec_rs2;
  logic [4:0]    dec_rd;
  logic          dec_use_rs1;
  logic          dec_use_rs2;
  logic          dec_write_rd;
  logic          iss_valid;
  logic          iss_ready;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic          flush;
  logic [CW-1:0] outstanding;
  logic          busy;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_write_rd,
    output iss_ready, wb_valid, wb_rd, flush,
    input  dec_ready, iss_valid, outstanding, busy
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_write_rd,
    input  iss_ready, wb_valid, wb_rd, flush,
    output dec_ready, iss_valid, outstanding, busy
  );
endinterface

// File: rtl/rv32_issue_scoreboard.sv
// rtl/rv32_issue_scoreboard.sv - register pending-write scoreboard gating in-order issue
// Optional same-cycle writeback bypass: define RV32_SCOREBOARD_BYPASS_EN.
module rv32_issue_scoreboard #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                    clk,
  input logic                    rst,
  rv32_issue_scoreboard_if.slave sb
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:1]   pending_q, pending_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [31:0]   pend_vec;
  logic [31:0]   pend_eff;
  logic [31:0]   pend_nxt;
  logic          at_max;
  logic          full;
  logic          hazard;
  logic          fire;
  logic          set_en;
  logic          clr_en;

  // Bit 0 is hardwired clear so x0 never creates a dependency.
  assign pend_vec = {pending_q, 1'b0};
  assign at_max   = (outstanding_q == CW'(MAX_OUTSTANDING));
  assign clr_en   = sb.wb_valid & pend_vec[sb.wb_rd];

  always_comb begin
    pend_eff = pend_vec;
    full     = at_max;
`ifdef RV32_SCOREBOARD_BYPASS_EN
    // A completing writeback releases its register and its counter slot this cycle.
    if (sb.wb_valid) pend_eff[sb.wb_rd] = 1'b0;
    if (clr_en) full = 1'b0;
`endif
    hazard = (sb.dec_use_rs1  & pend_eff[sb.dec_rs1])
           | (sb.dec_use_rs2  & pend_eff[sb.dec_rs2])
           | (sb.dec_write_rd & pend_eff[sb.dec_rd])
           | (sb.dec_write_rd & (sb.dec_rd != 5'd0) & full);
  end

  assign sb.iss_valid   = sb.dec_valid & ~hazard & ~sb.flush & ~rst;
  assign sb.dec_ready   = sb.iss_ready & ~hazard & ~sb.flush & ~rst;
  assign sb.outstanding = outstanding_q;
  assign sb.busy        = (outstanding_q != '0);

  assign fire   = sb.dec_valid & sb.dec_ready;
  assign set_en = fire & sb.dec_write_rd & (sb.dec_rd != 5'd0);

  always_comb begin
    pend_nxt      = pend_vec;
    outstanding_d = outstanding_q;
    // Clear before set so a bypassed same-register issue leaves the bit pending.
    if (clr_en) pend_nxt[sb.wb_rd] = 1'b0;
    if (set_en) pend_nxt[sb.dec_rd] = 1'b1;
    if (set_en && !clr_en) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!set_en && clr_en) begin
      outstanding_d = outstanding_q - CW'(1);
    end
    pending_d = pend_nxt[31:1];
    if (sb.flush) begin
      pending_d     = '0;
      outstanding_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      outstanding_q <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(set_en && !clr_en && at_max));
      assert (!(clr_en && !set_en && (outstanding_q == '0)));
    end
  end
endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// tb/tb_rv32_issue_scoreboard.sv - directed scoreboard bench for rv32_issue_scoreboard
module tb_rv32_issue_scoreboard;
`ifdef RV32_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic  iv;
    logic  dr;
    int    out;
    string name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  rv32_issue_scoreboard_if #(.MAX_OUTSTANDING(4)) sb_if ();

  rv32_issue_scoreboard #(.MAX_OUTSTANDING(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.name, "iss_valid",   int'(sb_if.iss_valid),   int'(e.iv));
        check(e.name, "dec_ready",   int'(sb_if.dec_ready),   int'(e.dr));
        check(e.name, "outstanding", int'(sb_if.outstanding), e.out);
        check(e.name, "busy",        int'(sb_if.busy),        (e.out != 0) ? 1 : 0);
      end
    end
  end

  task automatic drive_dec(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic wr);
    sb_if.dec_valid    = v;
    sb_if.dec_rs1      = rs1;
    sb_if.dec_use_rs1  = u1;
    sb_if.dec_rs2      = rs2;
    sb_if.dec_use_rs2  = u2;
    sb_if.dec_rd       = rd;
    sb_if.dec_write_rd = wr;
  endtask

  task automatic drive_ctl(input logic ir, input logic wv, input logic [4:0] wrd,
                           input logic fl, input logic r);
    sb_if.iss_ready = ir;
    sb_if.wb_valid  = wv;
    sb_if.wb_rd     = wrd;
    sb_if.flush     = fl;
    rst             = r;
  endtask

  task automatic expect_cyc(input logic iv, input logic dr, input int out, input string nm);
    exp_t e;
    e.iv = iv; e.dr = dr; e.out = out; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive_dec(0, 0, 0, 0, 0, 0, 0);
    drive_ctl(0, 0, 0, 0, 1);
    @(posedge clk);
    #1;

    drive_dec(1, 0, 0, 0, 0, 0, 0);
    drive_ctl(1, 0, 0, 0, 1);
    expect_cyc(0, 0, 0, "rst_force");

    drive_ctl(1, 0, 0, 0, 0);
    drive_dec(1, 0, 0, 0, 0, 5, 1);
    expect_cyc(1, 1, 0, "issue_rd5");
    drive_dec(1, 5, 1, 0, 0, 0, 0);
    expect_cyc(0, 0, 1, "raw_stall");
    drive_ctl(1, 1, 5, 0, 0);
    expect_cyc(BYP, BYP, 1, "raw_wb_cycle");
    drive_ctl(1, 0, 0, 0, 0);
    expect_cyc(1, 1, 0, "raw_after_wb");

    for (int i = 0; i < 4; i++) begin
      drive_dec(1, 0, 1, 0, 0, 0, 1);
      expect_cyc(1, 1, 0, "rd0_issue");
    end

    for (int i = 1; i <= 4; i++) begin
      drive_dec(1, 0, 0, 0, 0, 5'(i), 1);
      expect_cyc(1, 1, i - 1, "fill");
    end
    drive_dec(1, 0, 0, 0, 0, 6, 1);
    expect_cyc(0, 0, 4, "full_stall");
    drive_dec(1, 10, 1, 0, 0, 6, 0);
    expect_cyc(1, 1, 4, "full_nowrite");
    drive_dec(1, 0, 0, 0, 0, 0, 1);
    expect_cyc(1, 1, 4, "full_rd0");
    drive_dec(1, 0, 0, 0, 0, 6, 1);
    drive_ctl(1, 1, 1, 0, 0);
    expect_cyc(BYP, BYP, 4, "full_wb_cycle");
    drive_ctl(1, 0, 0, 0, 0);
    expect_cyc(!BYP, !BYP, BYP ? 4 : 3, "waw_or_refill");

    drive_dec(0, 0, 0, 0, 0, 0, 0);
    drive_ctl(1, 1, 6, 0, 0);
    expect_cyc(0, 1, 4, "wb6");
    drive_dec(1, 0, 0, 0, 0, 7, 1);
    drive_ctl(1, 1, 2, 0, 0);
    expect_cyc(1, 1, 3, "iss7_wb2");
    drive_dec(1, 7, 1, 0, 0, 0, 0);
    drive_ctl(0, 0, 0, 0, 0);
    expect_cyc(0, 0, 3, "p7_set");
    drive_dec(1, 2, 1, 0, 0, 0, 0);
    drive_ctl(0, 1, 2, 0, 0);
    expect_cyc(1, 0, 3, "p2_clr");

    drive_dec(1, 10, 1, 0, 0, 0, 0);
    drive_ctl(1, 0, 0, 1, 0);
    expect_cyc(0, 0, 3, "flush_cycle");
    drive_dec(0, 0, 0, 0, 0, 0, 0);
    drive_ctl(1, 1, 1, 0, 0);
    expect_cyc(0, 1, 0, "post_flush");
    drive_dec(1, 3, 1, 0, 0, 3, 1);
    drive_ctl(1, 0, 0, 0, 0);
    expect_cyc(1, 1, 0, "refill3");
    drive_dec(1, 0, 0, 0, 0, 9, 1);
    expect_cyc(1, 1, 1, "refill9");

    drive_dec(1, 3, 1, 0, 0, 0, 0);
    drive_ctl(1, 0, 0, 0, 1);
    expect_cyc(0, 0, 2, "rst_mid");
    drive_dec(1, 3, 1, 9, 1, 9, 1);
    drive_ctl(1, 0, 0, 0, 0);
    expect_cyc(1, 1, 0, "post_rst_issue");
    drive_dec(0, 0, 0, 0, 0, 0, 0);
    drive_ctl(1, 1, 9, 0, 0);
    expect_cyc(0, 1, 1, "wb9");
    drive_ctl(1, 0, 0, 0, 0);
    expect_cyc(0, 1, 0, "idle_end");

    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rv32_issue_scoreboard.md
RV32_ISSUE_SCOREBOARD -- requirements
Module: rv32_issue_scoreboard

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum number of issued, not-yet-written-back register writes (range 1..31).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 dec_valid  input  1  decoded instruction offered.
REQ-005 dec_ready  output  1  decoded instruction accepted this cycle.
REQ-006 dec_rs1, dec_rs2, dec_rd  input  5 each  register addresses from the decoded fields.
REQ-007 dec_use_rs1, dec_use_rs2, dec_write_rd  input  1 each  operand-read and destination-write enables.
REQ-008 iss_valid  output  1  instruction issued to execute.
REQ-009 iss_ready  input  1  execute stage can accept.
REQ-010 wb_valid  input  1  one register writeback completes this cycle.
REQ-011 wb_rd  input  5  writeback destination.
REQ-012 flush  input  1  discard all outstanding writes.
REQ-013 outstanding  output  $clog2(MAX_OUTSTANDING+1)  count of pending writes.
REQ-014 busy  output  1  outstanding != 0.

Function
REQ-015 State: pending[31:1] bit vector (x0 never pending, pending[0] reads 0) and outstanding counter.
REQ-016 hazard = (dec_use_rs1 & pending[dec_rs1]) | (dec_use_rs2 & pending[dec_rs2]) | (dec_write_rd & pending[dec_rd]) | (dec_write_rd & dec_rd!=0 & outstanding==MAX_OUTSTANDING).
REQ-017 iss_valid = dec_valid & ~hazard & ~flush; dec_ready = iss_ready & ~hazard & ~flush; both combinational, zero latency, no buffering.
REQ-018 Issue fires when dec_valid & dec_ready; if dec_write_rd and dec_rd!=0, next cycle pending[dec_rd]=1 and outstanding increments by 1.
REQ-019 Writeback with wb_valid and pending[wb_rd]=1: next cycle pending[wb_rd]=0, outstanding decrements by 1.
REQ-020 Writeback to a non-pending register or x0: ignored, no state change.
REQ-021 Same-cycle issue (set reg A) and writeback (clear reg B): both applied; outstanding net unchanged.
REQ-022 Same-cycle issue and writeback to the same register cannot both fire (WAW hazard blocks issue unless REQ-030 bypass clears it; then the pending bit ends set, count net unchanged).
REQ-023 flush: next cycle all pending bits 0, outstanding 0; flush dominates any same-cycle issue or writeback; no issue fires during flush.
REQ-024 Counter never wraps: increment at MAX_OUTSTANDING and decrement at 0 are impossible by construction; asserting otherwise is a design error.
REQ-025 dec_* fields may change while dec_valid=1 and dec_ready=0; no stability requirement on the decoder.

Reset
REQ-026 rst high at a clock edge: pending all 0, outstanding 0, busy 0.
REQ-027 During rst, iss_valid and dec_ready are forced 0.
REQ-028 Reset mid-operation discards all pending state; writebacks arriving after reset are ignored per REQ-020.

Configuration
REQ-029 Macro RV32_SCOREBOARD_BYPASS_EN selects same-cycle writeback bypass.
REQ-030 Defined: hazard evaluation treats pending[wb_rd] as 0 when wb_valid=1 (and a writeback frees a counter slot in the same cycle), so a dependent instruction issues in the writeback cycle.
REQ-031 Undefined: hazard uses registered state only; dependent instruction issues no earlier than the cycle after writeback.

Verification
REQ-032 Issue rd=5, then dec rs1=5 with iss_ready=1 -> stalled (iss_valid=0) until wb_rd=5; issues in wb cycle with BYPASS_EN, one cycle later without.
REQ-033 Issue rd=0 four times -> pending unchanged, outstanding stays 0, no stalls.
REQ-034 MAX_OUTSTANDING=4: issue rd=1,2,3,4 back-to-back -> outstanding=4; fifth instruction writing rd=6 stalls; instruction with dec_write_rd=0 and no hazard still issues.
REQ-035 outstanding=3, same cycle issue rd=7 and wb_rd=2 -> outstanding stays 3, pending[7]=1, pending[2]=0.
REQ-036 outstanding=3, flush with dec_valid=1 -> iss_valid=0 that cycle, next cycle outstanding=0, busy=0; subsequent wb_rd=1 ignored.
REQ-037 rst asserted with outstanding=2 -> next cycle outstanding=0, all hazards clear, formerly pending sources issue immediately.
